// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder controller: FSM state type,
// state-encoding width and the default operand width.
package serial_add_ctrl_pkg;

    localparam int unsigned STATE_W       = 2;
    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fadd.sv
// One-bit full adder FAdd: F = A ^ B ^ C1, C2 = carry out.
module FAdd (
    input  logic A,
    input  logic B,
    input  logic C1,
    output logic F,
    output logic C2
);

    // Combinational sum and carry of one bit position.
    always_comb begin
        F  = A ^ B ^ C1;
        C2 = (A & B) | (C1 & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial add controller: captures two WIDTH-bit operands and a carry-in,
// then adds them one bit per cycle (LSB first) through a single FAdd.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' input that
// selects a - b (b inverted, initial carry forced to 1).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] next_psum;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    FAdd u_fadd (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .C1 (carry),
        .F  (fa_s),
        .C2 (fa_c)
    );

    // Operand/carry values to capture on an accepted start.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    // New sum bit enters from the MSB side; written as shifts so WIDTH=1 needs no special slice.
    always_comb begin
        next_psum = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    psum  <= next_psum;
                    if (cnt == CNT_LAST) begin
                        sum   <= next_psum;
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_chk;
    int n_bad;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: busy for 8 cycles, done in cycle 9, then idle.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [7:0] es, input logic ec, input string tag);
        a = ia; b = ib; cin = ic; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            step();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy0"}, busy, 0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        step();
        chk({tag, "_done0"}, done, 0);
    endtask

    initial begin
        int n_done;
        n_chk = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #22;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        step();

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add5a3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addff01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "addffff1");

        // Start pulse and operand changes during RUN are ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("ign_busy", busy, 1);
            chk("ign_nodone", done, 0);
            if (i == 3) begin
                a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h46);
        chk("ign_cout", cout, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) n_done++;
            chk("ign_idle_busy", busy, 0);
        end
        chk("ign_extra_done", n_done, 0);

        // Reset in cycle 4 of RUN aborts immediately.
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 4; i++) step();
        chk("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "postrst");

        // Continuous start: launches every 10 cycles.
        a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            chk("b2b_busy", busy, ((c % 10) >= 1 && (c % 10) <= 8) ? 1 : 0);
            chk("b2b_done", done, ((c % 10) == 9) ? 1 : 0);
            if (done) begin
                n_done++;
                chk("b2b_sum", sum, 8'h78);
                chk("b2b_cout", cout, 0);
            end
        end
        start = 1'b0;
        chk("b2b_count", n_done, 3);
        for (int i = 0; i < 12; i++) step();

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub1001");
        run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, "sub0102");
        sub = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
